// File: rtl/nios_ii_system_timer_scheduler.sv
// Round-robin arbiter that lends one 16-bit interval timer to two requesters for a timed delay.
// It programs the period, starts a one-shot, waits for the interrupt and clears it, or aborts with a STOP.
module nios_ii_system_timer_scheduler #(
  parameter int unsigned WATCHDOG = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [31:0] period0,
  input  logic [31:0] period1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic        wdog_err,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic        tmr_irq
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, SETTLE, WR_CTRL, WAIT_IRQ, CLR_STAT, DONE, ABORT
  } state_t;

  state_t      r_state, w_nextState;
  logic        r_owner, w_nextOwner;
  logic        r_last, w_nextLast;
  logic [31:0] r_period, w_nextPeriod;
  logic        r_abortStep, w_nextAbortStep;
  logic [31:0] r_wdogCnt;
  logic        w_wdogFire, w_reqOwner;

  logic [1:0]  r_grant, r_done, w_grant, w_done;
  logic        r_wdogErr, r_cs, w_cs;
  logic [2:0]  r_addr, w_addr;
  logic [15:0] r_data, w_data;

  always_comb begin
    w_nextState     = r_state;
    w_nextOwner     = r_owner;
    w_nextLast      = r_last;
    w_nextPeriod    = r_period;
    w_nextAbortStep = 1'b0;
    w_wdogFire      = 1'b0;
    w_reqOwner      = req[r_owner];
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_nextOwner  = (req == 2'b11) ? ~r_last : req[1];
          w_nextLast   = w_nextOwner;
          w_nextPeriod = w_nextOwner ? period1 : period0;
          w_nextState  = WR_PL;
        end
      end
      WR_PL: begin
        if (r_period == 32'd0)  w_nextState = DONE;
        else if (!w_reqOwner)   w_nextState = ABORT;
        else                    w_nextState = WR_PH;
      end
      WR_PH:   w_nextState = w_reqOwner ? SETTLE   : ABORT;
      SETTLE:  w_nextState = w_reqOwner ? WR_CTRL  : ABORT;
      WR_CTRL: w_nextState = w_reqOwner ? WAIT_IRQ : ABORT;
      WAIT_IRQ: begin
        // A dropped request beats the interrupt; the interrupt beats the watchdog.
        if (!w_reqOwner) begin
          w_nextState = ABORT;
        end else if (tmr_irq) begin
          w_nextState = CLR_STAT;
        end else if ((WATCHDOG != 0) && (r_wdogCnt + 32'd1 == WATCHDOG)) begin
          w_nextState = ABORT;
          w_wdogFire  = 1'b1;
        end
      end
      CLR_STAT: w_nextState = DONE;
      DONE:     w_nextState = IDLE;
      ABORT: begin
        if (!r_abortStep) w_nextAbortStep = 1'b1;
        else              w_nextState     = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Bus and handshake outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    w_cs   = 1'b0;
    w_addr = 3'd0;
    w_data = 16'h0000;
    case (w_nextState)
      WR_PL: begin
        if (w_nextPeriod != 32'd0) begin
          w_cs   = 1'b1;
          w_addr = 3'd2;
          w_data = w_nextPeriod[15:0];
        end
      end
      WR_PH: begin
        w_cs   = 1'b1;
        w_addr = 3'd3;
        w_data = w_nextPeriod[31:16];
      end
      WR_CTRL: begin
        w_cs   = 1'b1;
        w_addr = 3'd1;
        w_data = 16'h0005;
      end
      CLR_STAT: w_cs = 1'b1;
      ABORT: begin
        w_cs   = 1'b1;
        w_addr = w_nextAbortStep ? 3'd0 : 3'd1;
        w_data = w_nextAbortStep ? 16'h0000 : 16'h0008;
      end
      default: w_cs = 1'b0;
    endcase
    w_grant = (w_nextState == IDLE) ? 2'b00 : (w_nextOwner ? 2'b10 : 2'b01);
    w_done  = (w_nextState == DONE) ? (w_nextOwner ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_period    <= 32'd0;
      r_abortStep <= 1'b0;
      r_wdogCnt   <= 32'd0;
      r_grant     <= 2'b00;
      r_done      <= 2'b00;
      r_wdogErr   <= 1'b0;
      r_cs        <= 1'b0;
      r_addr      <= 3'd0;
      r_data      <= 16'h0000;
    end else begin
      r_state     <= w_nextState;
      r_owner     <= w_nextOwner;
      r_last      <= w_nextLast;
      r_period    <= w_nextPeriod;
      r_abortStep <= w_nextAbortStep;
      if ((w_nextState == WAIT_IRQ) && (r_state != WAIT_IRQ)) r_wdogCnt <= 32'd0;
      else if (r_state == WAIT_IRQ)                           r_wdogCnt <= r_wdogCnt + 32'd1;
      r_grant     <= w_grant;
      r_done      <= w_done;
      r_wdogErr   <= w_wdogFire;
      r_cs        <= w_cs;
      r_addr      <= w_addr;
      r_data      <= w_data;
    end
  end

  assign grant          = r_grant;
  assign done           = r_done;
  assign wdog_err       = r_wdogErr;
  assign tmr_chipselect = r_cs;
  assign tmr_write_n    = ~r_cs;
  assign tmr_address    = r_addr;
  assign tmr_writedata  = r_data;

endmodule

// File: tb/tb_nios_ii_system_timer_scheduler.sv
// Bench for the timer scheduler: directed literal checks followed by random traffic,
// all cycles compared against a script-queue model of each owner's transaction.
module tb_nios_ii_system_timer_scheduler;
  localparam int WDOG = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req;
  logic [31:0] period0, period1;
  logic [1:0]  grant, done;
  logic        wdog_err;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  int total = 0;
  int bad   = 0;

  nios_ii_system_timer_scheduler #(.WATCHDOG(WDOG)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .period0(period0), .period1(period1),
    .grant(grant), .done(done), .wdog_err(wdog_err), .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  // One entry describes the outputs of one cycle of a granted transaction.
  typedef struct {
    bit        cs;
    bit [2:0]  a;
    bit [15:0] d;
    bit        dn;
    bit        wd;
    bit        ab;
  } step_t;

  step_t cur;
  step_t scr[$];
  bit    mBusy = 0, mWaiting = 0, mWaitAfter = 0;
  int    mOwner = 0, mLast = 1, mWcnt = 0;

  function automatic step_t mk(bit cs, bit [2:0] a, bit [15:0] d, bit dn, bit wd, bit ab);
    step_t s;
    s.cs = cs; s.a = a; s.d = d; s.dn = dn; s.wd = wd; s.ab = ab;
    return s;
  endfunction

  task automatic modelAbort(input bit wd);
    scr.delete();
    scr.push_back(mk(1, 3'd1, 16'h0008, 0, wd, 0));
    scr.push_back(mk(1, 3'd0, 16'h0000, 0, 0, 0));
    mWaiting   = 0;
    mWaitAfter = 0;
    cur = scr.pop_front();
  endtask

  initial cur = mk(0, 0, 0, 0, 0, 0);

  always @(posedge clk or negedge reset_n) begin
    logic [31:0] p;
    if (!reset_n) begin
      mBusy = 0; mWaiting = 0; mWaitAfter = 0; mLast = 1;
      scr.delete();
      cur = mk(0, 0, 0, 0, 0, 0);
    end else if (!mBusy) begin
      if (req != 2'b00) begin
        if (req == 2'b11) mOwner = 1 - mLast;
        else              mOwner = req[1] ? 1 : 0;
        mLast = mOwner;
        p = (mOwner == 1) ? period1 : period0;
        mBusy = 1;
        if (p == 32'd0) begin
          scr.push_back(mk(0, 0, 0, 0, 0, 0));
          scr.push_back(mk(0, 0, 0, 1, 0, 0));
          mWaitAfter = 0;
        end else begin
          scr.push_back(mk(1, 3'd2, p[15:0], 0, 0, 1));
          scr.push_back(mk(1, 3'd3, p[31:16], 0, 0, 1));
          scr.push_back(mk(0, 0, 0, 0, 0, 1));
          scr.push_back(mk(1, 3'd1, 16'h0005, 0, 0, 1));
          mWaitAfter = 1;
        end
        cur = scr.pop_front();
      end else begin
        cur = mk(0, 0, 0, 0, 0, 0);
      end
    end else if (mWaiting) begin
      if (!req[mOwner]) begin
        modelAbort(0);
      end else if (tmr_irq) begin
        mWaiting = 0;
        scr.push_back(mk(1, 3'd0, 16'h0000, 0, 0, 0));
        scr.push_back(mk(0, 0, 0, 1, 0, 0));
        cur = scr.pop_front();
      end else begin
        mWcnt++;
        if (WDOG != 0 && mWcnt == WDOG) modelAbort(1);
        else cur = mk(0, 0, 0, 0, 0, 1);
      end
    end else if (cur.ab && !req[mOwner]) begin
      modelAbort(0);
    end else if (scr.size() > 0) begin
      cur = scr.pop_front();
    end else if (mWaitAfter) begin
      mWaitAfter = 0; mWaiting = 1; mWcnt = 0;
      cur = mk(0, 0, 0, 0, 0, 1);
    end else begin
      mBusy = 0;
      cur = mk(0, 0, 0, 0, 0, 0);
    end
  end

  function automatic logic [25:0] pack(logic [1:0] g, logic [1:0] dn, logic wd, logic cs,
                                       logic wn, logic [2:0] a, logic [15:0] d);
    return {g, dn, wd, cs, wn, a, d};
  endfunction

  task automatic checkNow(input string nm, input logic [25:0] want);
    logic [25:0] got;
    got = pack(grant, done, wdog_err, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got g=%b dn=%b wd=%b cs=%b wn=%b a=%0d d=%h, want g=%b dn=%b wd=%b cs=%b wn=%b a=%0d d=%h",
               nm, $time, got[25:24], got[23:22], got[21], got[20], got[19], got[18:16], got[15:0],
               want[25:24], want[23:22], want[21], want[20], want[19], want[18:16], want[15:0]);
    end
  endtask

  task automatic checkOutput(input string nm, input logic [1:0] g, input logic [1:0] dn,
                             input logic wd, input logic cs, input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    checkNow(nm, pack(g, dn, wd, cs, ~cs, a, d));
    @(posedge clk); #1;
  endtask

  // Model comparison on every cycle outside reset.
  always @(negedge clk) begin
    logic [1:0] eg, ed;
    if (reset_n === 1'b1) begin
      eg = mBusy ? ((mOwner == 1) ? 2'b10 : 2'b01) : 2'b00;
      ed = cur.dn ? eg : 2'b00;
      checkNow("model", pack(eg, ed, cur.wd, cur.cs, ~cur.cs, cur.a, cur.d));
    end
  end

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            if (i == 0) period0 = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            else        period1 = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
          end
        end else if (done[i] && $urandom_range(1) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(29) == 0) begin
          req[i] = 1'b0;
        end
      end
      tmr_irq = ($urandom_range(7) == 0);
    end
  endtask

  initial begin
    reset_n = 1'b0; req = 2'b00; period0 = 32'd0; period1 = 32'd0; tmr_irq = 1'b0;
    #23 reset_n = 1'b1;
    @(posedge clk); #1;

    // Full timed delay for requester 0.
    req = 2'b01; period0 = 32'h0001_0003;
    checkOutput("idleN",  2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("wrPL",   2'b01, 2'b00, 0, 1, 3'd2, 16'h0003);
    checkOutput("wrPH",   2'b01, 2'b00, 0, 1, 3'd3, 16'h0001);
    checkOutput("settle", 2'b01, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("wrCtrl", 2'b01, 2'b00, 0, 1, 3'd1, 16'h0005);
    checkOutput("wait0",  2'b01, 2'b00, 0, 0, 3'd0, 16'h0000);
    tmr_irq = 1'b1;
    checkOutput("waitIrq", 2'b01, 2'b00, 0, 0, 3'd0, 16'h0000);
    tmr_irq = 1'b0;
    checkOutput("clrStat", 2'b01, 2'b00, 0, 1, 3'd0, 16'h0000);
    req = 2'b00;
    checkOutput("done0",  2'b01, 2'b01, 0, 0, 3'd0, 16'h0000);
    checkOutput("idleA",  2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);

    // Zero period on requester 1 skips the timer.
    req = 2'b10; period1 = 32'd0;
    checkOutput("zIdle",  2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("zGrant", 2'b10, 2'b00, 0, 0, 3'd0, 16'h0000);
    req = 2'b00;
    checkOutput("zDone",  2'b10, 2'b10, 0, 0, 3'd0, 16'h0000);
    checkOutput("zIdle2", 2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);

    // Reset during WR_PH, then re-service and abort on request drop.
    req = 2'b01; period0 = 32'h1234_5678;
    checkOutput("cIdle",  2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("cPL",    2'b01, 2'b00, 0, 1, 3'd2, 16'h5678);
    #2 reset_n = 1'b0;
    #1 checkNow("asyncReset", pack(2'b00, 2'b00, 0, 0, 1, 3'd0, 16'h0000));
    @(posedge clk); #2 reset_n = 1'b1;
    checkOutput("postRstIdle", 2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("postRstPL",   2'b01, 2'b00, 0, 1, 3'd2, 16'h5678);
    req = 2'b00;
    checkOutput("abPH",   2'b01, 2'b00, 0, 1, 3'd3, 16'h1234);
    checkOutput("abStop", 2'b01, 2'b00, 0, 1, 3'd1, 16'h0008);
    checkOutput("abClr",  2'b01, 2'b00, 0, 1, 3'd0, 16'h0000);
    checkOutput("abIdle", 2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);

    // Watchdog expiry with the interrupt never arriving.
    req = 2'b10; period1 = 32'd5;
    checkOutput("wIdle",   2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("wPL",     2'b10, 2'b00, 0, 1, 3'd2, 16'h0005);
    checkOutput("wPH",     2'b10, 2'b00, 0, 1, 3'd3, 16'h0000);
    checkOutput("wSettle", 2'b10, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("wCtrl",   2'b10, 2'b00, 0, 1, 3'd1, 16'h0005);
    for (int k = 0; k < WDOG; k++)
      checkOutput("wWait", 2'b10, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("wErr",    2'b10, 2'b00, 1, 1, 3'd1, 16'h0008);
    req = 2'b00;
    checkOutput("wClr",    2'b10, 2'b00, 0, 1, 3'd0, 16'h0000);
    checkOutput("wIdle2",  2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);

    // Both requesting: grants alternate starting with requester 0.
    req = 2'b11; period0 = 32'd0; period1 = 32'd0;
    checkOutput("rrIdle",  2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("rrA",     2'b01, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("rrADone", 2'b01, 2'b01, 0, 0, 3'd0, 16'h0000);
    checkOutput("rrGap1",  2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("rrB",     2'b10, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("rrBDone", 2'b10, 2'b10, 0, 0, 3'd0, 16'h0000);
    checkOutput("rrGap2",  2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);
    checkOutput("rrC",     2'b01, 2'b00, 0, 0, 3'd0, 16'h0000);
    req = 2'b00;
    checkOutput("rrCDone", 2'b01, 2'b01, 0, 0, 3'd0, 16'h0000);
    checkOutput("rrIdle2", 2'b00, 2'b00, 0, 0, 3'd0, 16'h0000);

    applyStimulus(4000);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
